// File: rtl/bram_uart_tx_pkg.sv
// Shared definitions for the BRAM-to-UART image transmitter: main FSM state
// codes, local state encodings and a counter-width helper.
package bram_uart_tx_pkg;

  // Main FSM state codes (shared with main_fsm)
  localparam logic [2:0] FSM_IDLE     = 3'b000;
  localparam logic [2:0] SEL_BKGD     = 3'b001;
  localparam logic [2:0] COLOR_EDITS  = 3'b010;
  localparam logic [2:0] ADD_EDITS    = 3'b011;
  localparam logic [2:0] SAVE_TO_BRAM = 3'b100;
  localparam logic [2:0] SEND_TO_PC   = 3'b101;

  // Read/sequencing FSM states
  typedef enum logic [2:0] {
    RD_IDLE,
    RD_FETCH,
    RD_WAIT,
    RD_LOAD,
    RD_SEND_HI,
    RD_SEND_LO,
    RD_DONE
  } rd_state_e;

  // Byte serialiser states
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // Width of a counter that must reach n-1 (at least 1 bit)
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser: start bit, d0..d7 LSB first, stop bit, each bit held
// for CLKS_PER_BIT cycles. ready is high only while idle.
module uart_byte_tx
  import bram_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 564
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int unsigned      CNT_W    = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);
  assign tx      = tx_q;
  assign ready   = ready_q;

  // Next-state logic: tx_d is set on each bit transition so the line is registered
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    unique case (state_q)
      TX_IDLE: begin
        if (start) begin
          state_d = TX_START;
          cnt_d   = '0;
          shreg_d = data;
          tx_d    = 1'b0;
          ready_d = 1'b0;
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_d = TX_DATA;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          state_d = TX_IDLE;
          cnt_d   = '0;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  // State registers with synchronous reset to an idle-high line
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: rtl/bram_uart_tx.sv
// Streams NUM_WORDS BRAM words (hi byte then lo byte) over UART once the main
// FSM enters SEND_TO_PC. Leaving SEND_TO_PC mid-transfer finishes the current
// frame and drops the rest.
module bram_uart_tx
  import bram_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 564,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned NUM_WORDS    = 43200,
  parameter int unsigned DATA_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        fsm_state,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              uart_tx,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              issued_q, issued_d;
  logic              in_send_q;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              in_send;
  logic              byte_start;
  logic [7:0]        byte_data;
  logic              byte_ready;

  assign in_send   = (fsm_state == SEND_TO_PC);
  assign start_d   = in_send & ~in_send_q;
  assign bram_addr = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk  (clk),
    .rst  (rst),
    .start(byte_start),
    .data (byte_data),
    .tx   (uart_tx),
    .ready(byte_ready)
  );

  // Sequencing: fetch word, wait BRAM latency, load, send hi then lo byte.
  // byte_start is decoded combinationally from issued_q so the serialiser
  // accepts in the same cycle and ready is already low on the next one.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    word_d     = word_q;
    issued_d   = issued_q;
    byte_start = 1'b0;
    byte_data  = word_q[15:8];
    unique case (state_q)
      RD_IDLE: begin
        if (start_q) begin
          state_d = RD_FETCH;
        end
      end
      RD_FETCH: state_d = in_send ? RD_WAIT : RD_IDLE;
      RD_WAIT:  state_d = in_send ? RD_LOAD : RD_IDLE;
      RD_LOAD: begin
        word_d   = bram_dout;
        issued_d = 1'b0;
        state_d  = in_send ? RD_SEND_HI : RD_IDLE;
      end
      RD_SEND_HI, RD_SEND_LO: begin
        byte_data = (state_q == RD_SEND_HI) ? word_q[15:8] : word_q[7:0];
        if (!issued_q) begin
          if (!in_send) begin
            state_d = RD_IDLE;
          end else if (byte_ready) begin
            byte_start = 1'b1;
            issued_d   = 1'b1;
          end
        end else if (byte_ready) begin
          issued_d = 1'b0;
          if (!in_send) begin
            state_d = RD_IDLE;
          end else if (state_q == RD_SEND_HI) begin
            state_d = RD_SEND_LO;
          end else if (idx_q == LAST_IDX) begin
            state_d = RD_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = RD_FETCH;
          end
        end
      end
      RD_DONE: begin
        if (!in_send) begin
          state_d = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
    if (state_d == RD_IDLE) begin
      idx_d    = '0;
      issued_d = 1'b0;
    end
    busy_d = !(state_d inside {RD_IDLE, RD_DONE});
    done_d = (state_d == RD_DONE);
  end

  // Registers: FSM, word index, word, start-edge detector and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RD_IDLE;
      idx_q     <= '0;
      word_q    <= '0;
      issued_q  <= 1'b0;
      in_send_q <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      issued_q  <= issued_d;
      in_send_q <= in_send;
      start_q   <= start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule
